// File: rtl/lcdfmt_pkg.sv
// Shared types and ASCII helpers for the LCD watch formatter.
package lcdfmt_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StConvert,
        StWaitDisp,
        StHoldoff
    } lcdfmt_state_e;

    localparam logic [7:0] SPACE     = 8'h20;
    localparam logic [7:0] ZERO      = 8'h30;
    localparam logic [7:0] ALPHA_OFS = 8'h37;

    function automatic logic [7:0] hex2ascii(input logic [3:0] nibble);
        return (nibble < 4'd10) ? (ZERO + {4'h0, nibble}) : (ALPHA_OFS + {4'h0, nibble});
    endfunction

endpackage

// File: rtl/lcd_watch_formatter.sv
// Renders NUM_CH watched channels as hex fields in an ASCII LCD frame, one nibble per cycle.
// Define LCDFMT_ZERO_BLANK_EN to blank leading zero digits within each field.
module lcd_watch_formatter
    import lcdfmt_pkg::*;
#(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned CH_W       = 32,
    parameter int unsigned DIGITS     = 6,
    parameter int unsigned LINE_CHARS = 16,
    parameter int unsigned LINES      = 2,
    parameter int unsigned HOLDOFF    = 1000
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_CH*CH_W-1:0]        ch_data_i,
    input  logic                          force_i,
    input  logic                          disp_busy_i,
    output logic [LINES*LINE_CHARS*8-1:0] strdata_o,
    output logic                          refresh_o,
    output logic                          busy_o
);

    localparam int unsigned CHARS  = LINES * LINE_CHARS;
    localparam int unsigned FieldW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned DigW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned PosW   = (CHARS > 1) ? $clog2(CHARS) : 1;
    localparam int unsigned CntW   = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

    localparam logic [FieldW-1:0] LastField = FieldW'(NUM_CH - 1);
    localparam logic [DigW-1:0]   LastDigit = DigW'(DIGITS - 1);

    lcdfmt_state_e               state_q, state_d;
    logic [NUM_CH-1:0][CH_W-1:0] snap_q, snap_d;
    logic [0:CHARS-1][7:0]       frame_q, frame_d;
    logic [FieldW-1:0]           field_q, field_d;
    logic [DigW-1:0]             digit_q, digit_d;
    logic [CntW-1:0]             cnt_q, cnt_d;
    logic                        pend_q, pend_d;
    logic                        seen_q, seen_d;
    logic                        refresh_q, refresh_d;

    logic [DIGITS-1:0][3:0] nibs;
    logic [3:0]             nib;
    logic [7:0]             ascii;
    logic [PosW-1:0]        pos;

    // Current nibble, MSB digit of the field first.
    always_comb begin
        nibs  = snap_q[field_q][DIGITS*4-1:0];
        nib   = nibs[LastDigit - digit_q];
        pos   = PosW'(32'(field_q) * (DIGITS + 1) + 32'(digit_q));
        ascii = hex2ascii(nib);
`ifdef LCDFMT_ZERO_BLANK_EN
        if (nib == 4'h0 && !seen_q && digit_q != LastDigit) begin
            ascii = SPACE;
        end
`endif
    end

    always_comb begin
        state_d   = state_q;
        snap_d    = snap_q;
        frame_d   = frame_q;
        field_d   = field_q;
        digit_d   = digit_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        seen_d    = seen_q;
        refresh_d = 1'b0;

        // A force outside IDLE is remembered and served on the next idle cycle.
        if (force_i && state_q != StIdle) begin
            pend_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (force_i || pend_q || (ch_data_i != snap_q)) begin
                    state_d = StConvert;
                    snap_d  = ch_data_i;
                    pend_d  = 1'b0;
                    field_d = '0;
                    digit_d = '0;
                    seen_d  = 1'b0;
                end
            end
            StConvert: begin
                frame_d[pos] = ascii;
                if (digit_q == LastDigit) begin
                    digit_d = '0;
                    seen_d  = 1'b0;
                    if (field_q == LastField) begin
                        state_d = StWaitDisp;
                    end else begin
                        field_d = field_q + FieldW'(1);
                    end
                end else begin
                    digit_d = digit_q + DigW'(1);
                    seen_d  = seen_q | (nib != 4'h0);
                end
            end
            StWaitDisp: begin
                if (!disp_busy_i) begin
                    state_d   = StHoldoff;
                    refresh_d = 1'b1;
                    cnt_d     = CntW'(HOLDOFF);
                end
            end
            StHoldoff: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            snap_q    <= '0;
            frame_q   <= {CHARS{SPACE}};
            field_q   <= '0;
            digit_q   <= '0;
            cnt_q     <= '0;
            pend_q    <= 1'b1;
            seen_q    <= 1'b0;
            refresh_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            snap_q    <= snap_d;
            frame_q   <= frame_d;
            field_q   <= field_d;
            digit_q   <= digit_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            seen_q    <= seen_d;
            refresh_q <= refresh_d;
        end
    end

    assign strdata_o = frame_q;
    assign refresh_o = refresh_q;
    assign busy_o    = (state_q != StIdle);

endmodule

// File: tb/tb_lcd_watch_formatter.sv
// Scoreboard bench for lcd_watch_formatter: expected frames and refresh cycles are queued
// at stimulus time and matched against refresh pulses captured by a monitor.
module tb_lcd_watch_formatter;

    localparam int NUM_CH     = 4;
    localparam int CH_W       = 32;
    localparam int DIGITS     = 6;
    localparam int LINE_CHARS = 16;
    localparam int LINES      = 2;
    localparam int HOLDOFF    = 1000;
    localparam int CHARS      = LINES * LINE_CHARS;
    localparam int FW         = CHARS * 8;
    localparam int DW         = NUM_CH * CH_W;
    localparam int LAT        = NUM_CH * DIGITS + 2;
    localparam int PERIOD     = NUM_CH * DIGITS + HOLDOFF + 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] ch_data = '0;
    logic          force_in = 1'b0;
    logic          disp_busy = 1'b0;
    logic [FW-1:0] strdata;
    logic          refresh;
    logic          busy;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    logic [FW-1:0] obs_f_q[$];
    int            obs_c_q[$];
    logic [FW-1:0] exp_f_q[$];
    int            exp_c_q[$];

    lcd_watch_formatter #(
        .NUM_CH    (NUM_CH),
        .CH_W      (CH_W),
        .DIGITS    (DIGITS),
        .LINE_CHARS(LINE_CHARS),
        .LINES     (LINES),
        .HOLDOFF   (HOLDOFF)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .ch_data_i  (ch_data),
        .force_i    (force_in),
        .disp_busy_i(disp_busy),
        .strdata_o  (strdata),
        .refresh_o  (refresh),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && refresh) begin
            obs_f_q.push_back(strdata);
            obs_c_q.push_back(cyc);
        end
    end

    function automatic logic [FW-1:0] model(input logic [DW-1:0] d);
        logic [FW-1:0]   f;
        logic [CH_W-1:0] v;
        logic [3:0]      nib;
        logic [7:0]      c;
`ifdef LCDFMT_ZERO_BLANK_EN
        bit lead = 1'b0;
`endif
        f = '0;
        for (int p = 0; p < CHARS; p++) begin
            int ch = p / (DIGITS + 1);
            int k  = p % (DIGITS + 1);
            c = 8'h20;
            if (ch < NUM_CH && k < DIGITS) begin
                v   = CH_W'(d >> (ch * CH_W));
                nib = 4'(v >> ((DIGITS - 1 - k) * 4));
                c   = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h41 + {4'h0, nib} - 8'd10);
`ifdef LCDFMT_ZERO_BLANK_EN
                if (k == 0) lead = 1'b1;
                if (lead && nib == 4'h0 && k != DIGITS - 1) c = 8'h20;
                else lead = 1'b0;
`endif
            end
            f = {f[FW-9:0], c};
        end
        return f;
    endfunction

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_wait: busy=%b after %0d cycles, required 0", busy, n);
        end
    endtask

    task automatic get_refresh(output bit got, output logic [FW-1:0] f, output int c);
        int n = 0;
        while (obs_f_q.size() == 0 && n < 1200) begin
            @(negedge clk);
            n++;
        end
        got = (obs_f_q.size() != 0);
        f   = '0;
        c   = -1;
        if (got) begin
            f = obs_f_q.pop_front();
            c = obs_c_q.pop_front();
        end
    endtask

    task automatic test_reset();
        bit got;
        logic [FW-1:0] f, ef;
        int c, ec;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if (strdata !== {CHARS{8'h20}}) begin
            n_fail++;
            $display("FAIL reset_strdata: got %h required all spaces", strdata);
        end
        n_tests++;
        if (refresh !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: refresh=%b busy=%b required 0 0", refresh, busy);
        end
        rst = 1'b0;
        exp_f_q.push_back(model(ch_data));
        exp_c_q.push_back(cyc + LAT);
        get_refresh(got, f, c);
        ef = exp_f_q.pop_front();
        ec = exp_c_q.pop_front();
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL reset_first_frame: no refresh, required one at cycle %0d", ec);
        end else begin
            if (f !== ef) begin n_fail++; $display("FAIL reset_frame: got %h required %h", f, ef); end
            n_tests++;
            if (c !== ec) begin n_fail++; $display("FAIL reset_latency: got %0d required %0d", c, ec); end
        end
    endtask

    task automatic test_data();
        bit got;
        logic [FW-1:0] f, ef;
        int c, ec;
        wait_idle();
        ch_data[0 +: CH_W]        = 32'h00ABCDEF;
        ch_data[3*CH_W +: CH_W]   = 32'h12345678;
        exp_f_q.push_back(model(ch_data));
        exp_c_q.push_back(cyc + LAT);
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL data_busy: got %b required 1", busy); end
        get_refresh(got, f, c);
        ef = exp_f_q.pop_front();
        ec = exp_c_q.pop_front();
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL data_refresh: no refresh, required one at cycle %0d", ec);
        end else begin
            if (f !== ef) begin n_fail++; $display("FAIL data_frame: got %h required %h", f, ef); end
            n_tests++;
            if (c !== ec) begin n_fail++; $display("FAIL data_latency: got %0d required %0d", c, ec); end
            n_tests++;
            if (f[FW-1 -: 48] !== 48'h414243444546) begin
                n_fail++;
                $display("FAIL data_ch0_text: got %h required 414243444546", f[FW-1 -: 48]);
            end
            n_tests++;
            if (f[FW-1-21*8 -: 48] !== 48'h333435363738) begin
                n_fail++;
                $display("FAIL data_ch3_text: got %h required 333435363738", f[FW-1-21*8 -: 48]);
            end
        end
        wait_idle();
        repeat (30) @(negedge clk);
        n_tests++;
        if (obs_f_q.size() != 0) begin
            n_fail++;
            $display("FAIL data_single_pulse: got %0d extra refreshes required 0", obs_f_q.size());
        end
    endtask

    task automatic test_disp_busy();
        bit got, stable;
        logic [FW-1:0] f, ef, snap;
        int c, ec, d;
        wait_idle();
        d = cyc;
        ch_data[2*CH_W +: CH_W] = 32'h0000F00D;
        disp_busy = 1'b1;
        exp_f_q.push_back(model(ch_data));
        exp_c_q.push_back(d + LAT + 50);
        wait_cyc(d + LAT);
        snap   = strdata;
        stable = 1'b1;
        while (cyc < d + LAT + 49) begin
            @(negedge clk);
            if (strdata !== snap || refresh !== 1'b0 || busy !== 1'b1) stable = 1'b0;
        end
        disp_busy = 1'b0;
        n_tests++;
        if (snap !== model(ch_data)) begin
            n_fail++;
            $display("FAIL wait_disp_frame: got %h required %h", snap, model(ch_data));
        end
        n_tests++;
        if (!stable) begin n_fail++; $display("FAIL wait_disp_stable: got unstable required stable"); end
        get_refresh(got, f, c);
        ef = exp_f_q.pop_front();
        ec = exp_c_q.pop_front();
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL busy_refresh: no refresh, required one at cycle %0d", ec);
        end else begin
            if (f !== ef) begin n_fail++; $display("FAIL busy_frame: got %h required %h", f, ef); end
            n_tests++;
            if (c !== ec) begin n_fail++; $display("FAIL busy_latency: got %0d required %0d", c, ec); end
        end
    endtask

    task automatic test_holdoff_changes();
        bit got;
        logic [FW-1:0] f, ef;
        int c, ec, fc;
        for (int r = 0; r < 2; r++) begin
            if (r == 0) begin
                wait_idle();
                ch_data[CH_W +: CH_W] = 32'h00000001;
                fc = cyc + LAT;
                exp_f_q.push_back(model(ch_data));
                exp_c_q.push_back(fc);
            end else begin
                wait_cyc(fc + 100);
                ch_data[CH_W +: CH_W] = 32'h00000222;
                wait_cyc(fc + 200);
                ch_data[CH_W +: CH_W] = 32'h00333333;
                wait_cyc(fc + 300);
                ch_data[CH_W +: CH_W] = 32'h00C0FFEE;
                exp_f_q.push_back(model(ch_data));
                exp_c_q.push_back(fc + PERIOD);
            end
            get_refresh(got, f, c);
            ef = exp_f_q.pop_front();
            ec = exp_c_q.pop_front();
            n_tests++;
            if (!got) begin
                n_fail++;
                $display("FAIL holdoff_refresh%0d: no refresh, required one at cycle %0d", r, ec);
            end else begin
                if (f !== ef) begin
                    n_fail++;
                    $display("FAIL holdoff_frame%0d: got %h required %h", r, f, ef);
                end
                n_tests++;
                if (c !== ec) begin
                    n_fail++;
                    $display("FAIL holdoff_cycle%0d: got %0d required %0d", r, c, ec);
                end
            end
        end
        wait_idle();
        repeat (30) @(negedge clk);
        n_tests++;
        if (obs_f_q.size() != 0) begin
            n_fail++;
            $display("FAIL holdoff_single: got %0d extra refreshes required 0", obs_f_q.size());
        end
    endtask

    task automatic test_force();
        bit got;
        logic [FW-1:0] f, ef;
        int c, ec, d;
        wait_idle();
        d = cyc;
        force_in = 1'b1;
        @(negedge clk);
        force_in = 1'b0;
        exp_f_q.push_back(model(ch_data));
        exp_c_q.push_back(d + LAT);
        exp_f_q.push_back(model(ch_data));
        exp_c_q.push_back(d + LAT + PERIOD);
        wait_cyc(d + 5);
        force_in = 1'b1;
        @(negedge clk);
        force_in = 1'b0;
        for (int r = 0; r < 2; r++) begin
            get_refresh(got, f, c);
            ef = exp_f_q.pop_front();
            ec = exp_c_q.pop_front();
            n_tests++;
            if (!got) begin
                n_fail++;
                $display("FAIL force_refresh%0d: no refresh, required one at cycle %0d", r, ec);
            end else begin
                if (f !== ef) begin
                    n_fail++;
                    $display("FAIL force_frame%0d: got %h required %h", r, f, ef);
                end
                n_tests++;
                if (c !== ec) begin
                    n_fail++;
                    $display("FAIL force_cycle%0d: got %0d required %0d", r, c, ec);
                end
            end
        end
        wait_idle();
        repeat (30) @(negedge clk);
        n_tests++;
        if (obs_f_q.size() != 0) begin
            n_fail++;
            $display("FAIL force_extra: got %0d extra refreshes required 0", obs_f_q.size());
        end
    endtask

    task automatic test_force_with_change();
        bit got;
        logic [FW-1:0] f, ef;
        int c, ec;
        wait_idle();
        force_in = 1'b1;
        ch_data[2*CH_W +: CH_W] = 32'h0BADC0DE;
        exp_f_q.push_back(model(ch_data));
        exp_c_q.push_back(cyc + LAT);
        @(negedge clk);
        force_in = 1'b0;
        get_refresh(got, f, c);
        ef = exp_f_q.pop_front();
        ec = exp_c_q.pop_front();
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL fwc_refresh: no refresh, required one at cycle %0d", ec);
        end else begin
            if (f !== ef) begin n_fail++; $display("FAIL fwc_frame: got %h required %h", f, ef); end
            n_tests++;
            if (c !== ec) begin n_fail++; $display("FAIL fwc_cycle: got %0d required %0d", c, ec); end
        end
        wait_idle();
        repeat (30) @(negedge clk);
        n_tests++;
        if (obs_f_q.size() != 0) begin
            n_fail++;
            $display("FAIL fwc_single: got %0d extra refreshes required 0", obs_f_q.size());
        end
    endtask

    task automatic test_reset_mid();
        bit got;
        logic [FW-1:0] f, ef;
        int c, ec, d;
        wait_idle();
        d = cyc;
        ch_data[0 +: CH_W] = 32'h00000042;
        wait_cyc(d + 10);
        rst = 1'b1;
        #1;
        n_tests++;
        if (strdata !== {CHARS{8'h20}}) begin
            n_fail++;
            $display("FAIL midrst_strdata: got %h required all spaces", strdata);
        end
        n_tests++;
        if (refresh !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_flags: refresh=%b busy=%b required 0 0", refresh, busy);
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if (obs_f_q.size() != 0) begin
            n_fail++;
            $display("FAIL midrst_no_pulse: got %0d refreshes required 0", obs_f_q.size());
        end
        rst = 1'b0;
        exp_f_q.push_back(model(ch_data));
        exp_c_q.push_back(cyc + LAT);
        get_refresh(got, f, c);
        ef = exp_f_q.pop_front();
        ec = exp_c_q.pop_front();
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL midrst_redraw: no refresh, required one at cycle %0d", ec);
        end else begin
            if (f !== ef) begin n_fail++; $display("FAIL midrst_frame: got %h required %h", f, ef); end
            n_tests++;
            if (c !== ec) begin n_fail++; $display("FAIL midrst_cycle: got %0d required %0d", c, ec); end
        end
    endtask

    initial begin
        test_reset();
        test_data();
        test_disp_busy();
        test_holdoff_changes();
        test_force();
        test_force_with_change();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
